// File: rtl/ysyx_040066_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_040066_axi_bridge
// Brief    : Fetch/data read arbiter and line-buffered writer onto one AXI4
//            master (32-bit address, 64-bit data).
// Revision : 1.0
// ============================================================================
module ysyx_040066_axi_bridge #(
    parameter int AXI_ID_W = 4,
    parameter int INS_ID   = 0,
    parameter int DATA_ID  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ins_req,
    input  logic                ins_burst,
    input  logic [63:0]         ins_addr,
    output logic                ins_ready,
    output logic                ins_last,
    output logic                ins_err,
    output logic [63:0]         ins_data,
    input  logic                rd_req,
    input  logic                rd_burst,
    input  logic [2:0]          rd_len,
    input  logic [63:0]         rd_addr,
    output logic                rd_ready,
    output logic                rd_last,
    output logic                rd_err,
    output logic [63:0]         rd_data,
    input  logic                wr_req,
    input  logic                wr_burst,
    input  logic [2:0]          wr_len,
    input  logic [7:0]          wr_mask,
    input  logic [63:0]         wr_addr,
    input  logic [511:0]        wr_data,
    output logic                wr_ready,
    output logic                wr_err,
    output logic                awvalid,
    input  logic                awready,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [AXI_ID_W-1:0] awid,
    output logic                wvalid,
    input  logic                wready,
    output logic [63:0]         wdata,
    output logic [7:0]          wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    input  logic [AXI_ID_W-1:0] bid,
    output logic                arvalid,
    input  logic                arready,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [AXI_ID_W-1:0] arid,
    input  logic                rvalid,
    output logic                rready,
    input  logic [1:0]          rresp,
    input  logic [AXI_ID_W-1:0] rid,
    input  logic [63:0]         rdata,
    input  logic                rlast
);
    localparam logic [1:0] R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] C_INCR = 2'b01;

    logic [1:0]       r_rstate, w_rnext, r_wstate, w_wnext;
    logic             r_owner_data, r_rburst, r_rerr;
    logic [31:0]      r_raddr, r_waddr;
    logic [2:0]       r_rsize, r_wsize, r_wcnt;
    logic             r_wburst, r_aw_done, r_w_done;
    logic [7:0]       r_wmask;
    logic [7:0][63:0] r_wbuf;
    logic             r_ins_ready, r_ins_last, r_ins_err, r_rd_ready, r_rd_last, r_rd_err;
    logic [63:0]      r_ins_data, r_rd_data;
    logic             r_wr_ready, r_wr_err;

    // A requester's req is ignored while its own completion strobe is showing.
    logic w_rd_grant, w_ins_grant, w_wr_grant, w_r_hs, w_aw_hs, w_w_hs, w_w_end;
    assign w_rd_grant  = rd_req && !(r_rd_ready && r_rd_last);
    assign w_ins_grant = ins_req && !(r_ins_ready && r_ins_last) && !w_rd_grant;
    assign w_wr_grant  = wr_req && !r_wr_ready;
    assign w_r_hs      = rvalid && rready;
    assign w_aw_hs     = awvalid && awready;
    assign w_w_hs      = wvalid && wready;
    assign w_w_end     = w_w_hs && wlast;

    logic w_unused;
    assign w_unused = ^{ins_addr[63:32], rd_addr[63:32], wr_addr[63:32], bid, rid, rresp[0], bresp[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_wstate <= W_IDLE;
        end else begin
            r_rstate <= w_rnext;
            r_wstate <= w_wnext;
        end
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_rd_grant || w_ins_grant) w_rnext = R_AR;
            R_AR:    if (arready) w_rnext = R_DATA;
            R_DATA:  if (rvalid && rlast) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_wr_grant) w_wnext = W_REQ;
            W_REQ:   if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_end)) w_wnext = W_RESP;
            W_RESP:  if (bvalid) w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    // AXI request fields are forced to zero whenever their valid is low.
    always_comb begin
        arvalid = (r_rstate == R_AR);
        rready  = (r_rstate == R_DATA);
        araddr  = arvalid ? r_raddr : 32'd0;
        arlen   = (arvalid && r_rburst) ? 8'd7 : 8'd0;
        arsize  = arvalid ? r_rsize : 3'd0;
        arburst = arvalid ? C_INCR : 2'b00;
        arid    = !arvalid ? '0 : r_owner_data ? AXI_ID_W'(DATA_ID) : AXI_ID_W'(INS_ID);
        awvalid = (r_wstate == W_REQ) && !r_aw_done;
        wvalid  = (r_wstate == W_REQ) && !r_w_done;
        bready  = (r_wstate == W_RESP);
        awaddr  = awvalid ? r_waddr : 32'd0;
        awlen   = (awvalid && r_wburst) ? 8'd7 : 8'd0;
        awsize  = awvalid ? r_wsize : 3'd0;
        awburst = awvalid ? C_INCR : 2'b00;
        awid    = awvalid ? AXI_ID_W'(DATA_ID) : '0;
        wdata   = wvalid ? r_wbuf[r_wcnt] : 64'd0;
        wstrb   = !wvalid ? 8'h00 : r_wburst ? 8'hFF : r_wmask;
        wlast   = wvalid && (!r_wburst || (r_wcnt == 3'd7));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_data <= 1'b0; r_rburst <= 1'b0; r_rerr <= 1'b0;
            r_raddr <= 32'd0; r_rsize <= 3'd0;
            r_ins_ready <= 1'b0; r_ins_last <= 1'b0; r_ins_err <= 1'b0; r_ins_data <= 64'd0;
            r_rd_ready <= 1'b0; r_rd_last <= 1'b0; r_rd_err <= 1'b0; r_rd_data <= 64'd0;
        end else begin
            r_ins_ready <= 1'b0; r_ins_last <= 1'b0; r_ins_err <= 1'b0; r_ins_data <= 64'd0;
            r_rd_ready <= 1'b0; r_rd_last <= 1'b0; r_rd_err <= 1'b0; r_rd_data <= 64'd0;
            if (r_rstate == R_IDLE && (w_rd_grant || w_ins_grant)) begin
                r_owner_data <= w_rd_grant;
                r_rerr       <= 1'b0;
                if (w_rd_grant) begin
                    r_rburst <= rd_burst;
                    r_raddr  <= rd_burst ? {rd_addr[31:6], 6'b0} : rd_addr[31:0];
                    r_rsize  <= rd_burst ? 3'd3 : rd_len;
                end else begin
                    r_rburst <= ins_burst;
                    r_raddr  <= ins_burst ? {ins_addr[31:6], 6'b0} : ins_addr[31:0];
                    r_rsize  <= ins_burst ? 3'd3 : 3'd2;
                end
            end
            if (w_r_hs) begin
                r_rerr <= r_rerr | rresp[1];
                if (r_owner_data) begin
                    r_rd_ready <= 1'b1; r_rd_data <= rdata; r_rd_last <= rlast;
                    r_rd_err   <= rlast & (r_rerr | rresp[1]);
                end else begin
                    r_ins_ready <= 1'b1; r_ins_data <= rdata; r_ins_last <= rlast;
                    r_ins_err   <= rlast & (r_rerr | rresp[1]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waddr <= 32'd0; r_wsize <= 3'd0; r_wburst <= 1'b0; r_wmask <= 8'd0;
            r_wbuf <= '0; r_wcnt <= 3'd0; r_aw_done <= 1'b0; r_w_done <= 1'b0;
            r_wr_ready <= 1'b0; r_wr_err <= 1'b0;
        end else begin
            r_wr_ready <= 1'b0;
            r_wr_err   <= 1'b0;
            if (r_wstate == W_IDLE && w_wr_grant) begin
                r_waddr   <= wr_burst ? {wr_addr[31:6], 6'b0} : wr_addr[31:0];
                r_wsize   <= wr_burst ? 3'd3 : wr_len;
                r_wburst  <= wr_burst;
                r_wmask   <= wr_mask;
                r_wbuf    <= wr_data;
                r_wcnt    <= 3'd0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_wcnt    <= r_wcnt + 3'd1;
            if (w_w_end) r_w_done  <= 1'b1;
            if (bready && bvalid) begin
                r_wr_ready <= 1'b1;
                r_wr_err   <= bresp[1];
            end
        end
    end

    assign ins_ready = r_ins_ready;
    assign ins_last  = r_ins_last;
    assign ins_err   = r_ins_err;
    assign ins_data  = r_ins_data;
    assign rd_ready  = r_rd_ready;
    assign rd_last   = r_rd_last;
    assign rd_err    = r_rd_err;
    assign rd_data   = r_rd_data;
    assign wr_ready  = r_wr_ready;
    assign wr_err    = r_wr_err;
endmodule
`default_nettype wire
